// File: rtl/axis_rr_arbiter.sv
// N-to-1 AXI-Stream beat arbiter: round-robin grant with a bounded burst per grant,
// feeding a single registered output stage that reports the source port on m_tid.
module axis_rr_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int TDATA_BYTES = 1,
    parameter int MAX_BURST   = 4
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic [NUM_PORTS*TDATA_BYTES*8-1:0]   s_tdata,
    input  logic [NUM_PORTS-1:0]                 s_tvalid,
    output logic [NUM_PORTS-1:0]                 s_tready,
    output logic [TDATA_BYTES*8-1:0]             m_tdata,
    output logic                                 m_tvalid,
    input  logic                                 m_tready,
    output logic [$clog2(NUM_PORTS)-1:0]         m_tid
);

    localparam int DW = TDATA_BYTES * 8;
    localparam int IW = $clog2(NUM_PORTS);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_reg;
    logic [IW-1:0]   rr_ptr_reg;
    logic [IW-1:0]   grant_reg;
    logic [7:0]      burst_cnt_reg;
    logic [DW-1:0]   m_tdata_reg;
    logic [IW-1:0]   m_tid_reg;
    logic            m_tvalid_reg;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [DW-1:0]   port_data [NUM_PORTS];
    logic [DW-1:0]   grant_data;
    logic            out_free;
    logic            hs;
    logic            grant_valid;
    logic            last_beat;
    logic [IW-1:0]   next_ptr;

    // Scan downward so the lowest offset from rr_ptr is the one that sticks.
    always_comb begin
        int idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (s_tvalid[IW'(idx)]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(idx);
            end
        end
    end

    assign out_free = !m_tvalid_reg || m_tready;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_data[gi] = s_tdata[gi*DW +: DW];
            assign s_tready[gi]  = (state_reg == GRANT) && (grant_reg == IW'(gi))
                                   && s_tvalid[gi] && out_free;
        end
    endgenerate

    assign grant_data  = port_data[grant_reg];
    assign hs          = |s_tready;
    assign grant_valid = s_tvalid[grant_reg];
    assign last_beat   = (burst_cnt_reg == 8'(MAX_BURST - 1));
    assign next_ptr    = (grant_reg == IW'(NUM_PORTS - 1)) ? '0 : grant_reg + 1'b1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            grant_reg     <= '0;
            burst_cnt_reg <= '0;
            m_tdata_reg   <= '0;
            m_tid_reg     <= '0;
            m_tvalid_reg  <= 1'b0;
        end else begin
            // A load always wins over a drain, giving one beat per clock when both happen.
            if (hs) begin
                m_tdata_reg  <= grant_data;
                m_tid_reg    <= grant_reg;
                m_tvalid_reg <= 1'b1;
            end else if (m_tready) begin
                m_tvalid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        grant_reg     <= pick_idx;
                        burst_cnt_reg <= '0;
                        state_reg     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!grant_valid) begin
                        state_reg  <= IDLE;
                        rr_ptr_reg <= next_ptr;
                    end else if (hs) begin
                        burst_cnt_reg <= burst_cnt_reg + 8'd1;
                        if (last_beat) begin
                            state_reg  <= IDLE;
                            rr_ptr_reg <= next_ptr;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign m_tdata  = m_tdata_reg;
    assign m_tid    = m_tid_reg;
    assign m_tvalid = m_tvalid_reg;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: per-port source queues, an output scoreboard
// of expected {tid,data} beats, and beat-spacing checks for grant/bubble timing.
module tb_axis_rr_arbiter;

    localparam int NP = 4;
    localparam int DW = 8;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [NP*DW-1:0]  s_tdata = '0;
    logic [NP-1:0]     s_tvalid = '0;
    logic [NP-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic [1:0]        m_tid;

    always #5 aclk = ~aclk;

    axis_rr_arbiter #(.NUM_PORTS(NP), .TDATA_BYTES(1), .MAX_BURST(4)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tid    (m_tid)
    );

    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [7:0]  src_q [NP][$];
    logic [9:0]  sb [$];
    int          beat_cyc [$];
    int          gaps_exp [$];
    logic [NP-1:0] hs_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0) begin
                s_tvalid[p]        = 1'b1;
                s_tdata[p*DW +: DW] = src_q[p][0];
            end else begin
                s_tvalid[p]        = 1'b0;
                s_tdata[p*DW +: DW] = '0;
            end
        end
    endtask

    // Sample at the falling edge, update sources just after the rising edge.
    task automatic step();
        logic [9:0] e;
        @(negedge aclk);
        hs_s = s_tvalid & s_tready;
        chk("tready_onehot0", 32'($onehot0(s_tready)), 32'd1);
        if (m_tvalid && m_tready) begin
            $display("cyc %0d beat tid=%0d data=0x%02h", cyc, m_tid, m_tdata);
            beat_cyc.push_back(cyc);
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_beat: observed tid=%0d data=0x%02h expected no beat", m_tid, m_tdata);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("beat_tid", 32'(m_tid), 32'(e[9:8]));
                chk("beat_data", 32'(m_tdata), 32'(e[7:0]));
            end
        end
        @(posedge aclk);
        cyc++;
        #1;
        for (int p = 0; p < NP; p++) begin
            if (hs_s[p] && src_q[p].size() > 0) src_q[p].delete(0);
        end
        refresh();
    endtask

    function automatic bit src_busy();
        bit b;
        b = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0) b = 1'b1;
        end
        return b;
    endfunction

    task automatic drain(input string tag);
        int budget;
        budget = 200;
        while ((sb.size() != 0 || src_busy()) && budget > 0) begin
            step();
            budget--;
        end
        chk(tag, 32'(sb.size()), 32'd0);
        repeat (4) step();
    endtask

    task automatic chk_gaps(input string tag);
        chk({tag, "_count"}, 32'(beat_cyc.size()), 32'(gaps_exp.size() + 1));
        for (int i = 0; i < gaps_exp.size() && i + 1 < beat_cyc.size(); i++) begin
            chk(tag, 32'(beat_cyc[i+1] - beat_cyc[i]), 32'(gaps_exp[i]));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with requests present to show s_tready stays low.
        aresetn  = 1'b0;
        s_tvalid = '1;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata", 32'(m_tdata), 32'd0);
        chk("rst_m_tid", 32'(m_tid), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        s_tvalid = '0;
        aresetn  = 1'b1;
        m_tready = 1'b1;
        step();
        step();
        chk("idle_m_tvalid", 32'(m_tvalid), 32'd0);

        // Single port 2 stream of 10 beats.
        beat_cyc.delete();
        for (int n = 0; n < 10; n++) begin
            src_q[2].push_back(8'(n));
            sb.push_back({2'd2, 8'(n)});
        end
        refresh();
        step();
        chk("t1_lat1_m_tvalid", 32'(m_tvalid), 32'd0);
        step();
        chk("t1_lat2_m_tvalid", 32'(m_tvalid), 32'd1);
        chk("t1_lat2_m_tdata", 32'(m_tdata), 32'd0);
        drain("t1_drain");
        gaps_exp = '{1, 1, 1, 2, 1, 1, 1, 2, 1};
        chk_gaps("t1_gap");

        // All ports busy from rr_ptr=0: bursts of 4 rotating 0,1,2,3,0,...
        aresetn = 1'b0;
        @(posedge aclk);
        cyc++;
        #1;
        aresetn = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++)
                for (int n = 0; n < 4; n++)
                    sb.push_back({2'(p), 8'(p*16 + r*4 + n)});
        for (int p = 0; p < NP; p++)
            for (int n = 0; n < 8; n++)
                src_q[p].push_back(8'(p*16 + n));
        refresh();
        drain("t2_drain");

        // Port 1 alone to move rr_ptr to 2, then ports 1 and 3 -> 3 wins first.
        src_q[1].push_back(8'hA0);
        sb.push_back({2'd1, 8'hA0});
        refresh();
        drain("t3_prep_drain");
        src_q[1].push_back(8'h11);
        src_q[1].push_back(8'h12);
        src_q[3].push_back(8'h31);
        src_q[3].push_back(8'h32);
        sb.push_back({2'd3, 8'h31});
        sb.push_back({2'd3, 8'h32});
        sb.push_back({2'd1, 8'h11});
        sb.push_back({2'd1, 8'h12});
        refresh();
        drain("t3_drain");

        // Port 0 stream with a 5-cycle stall after two beats of the burst.
        for (int n = 0; n < 6; n++) begin
            src_q[0].push_back(8'(8'h40 + n));
            sb.push_back({2'd0, 8'(8'h40 + n)});
        end
        refresh();
        repeat (3) step();
        m_tready = 1'b0;
        repeat (5) begin
            step();
            chk("t4_hold_m_tvalid", 32'(m_tvalid), 32'd1);
            chk("t4_hold_m_tdata", 32'(m_tdata), 32'h41);
            chk("t4_hold_m_tid", 32'(m_tid), 32'd0);
            chk("t4_hold_s_tready", 32'(s_tready), 32'd0);
        end
        beat_cyc.delete();
        m_tready = 1'b1;
        drain("t4_drain");
        gaps_exp = '{1, 1, 2, 1};
        chk_gaps("t4_gap");

        // Port 1 stops after 2 beats while port 2 waits.
        beat_cyc.delete();
        src_q[1].push_back(8'h51);
        src_q[1].push_back(8'h52);
        src_q[2].push_back(8'h61);
        src_q[2].push_back(8'h62);
        sb.push_back({2'd1, 8'h51});
        sb.push_back({2'd1, 8'h52});
        sb.push_back({2'd2, 8'h61});
        sb.push_back({2'd2, 8'h62});
        refresh();
        drain("t5_drain");
        gaps_exp = '{1, 3, 1};
        chk_gaps("t5_gap");

        // Asynchronous reset while port 3 holds a grant and a beat is stalled.
        m_tready = 1'b0;
        src_q[3].push_back(8'h90);
        src_q[3].push_back(8'h91);
        src_q[3].push_back(8'h92);
        refresh();
        repeat (3) step();
        chk("t6_pre_m_tvalid", 32'(m_tvalid), 32'd1);
        chk("t6_pre_m_tid", 32'(m_tid), 32'd3);
        aresetn = 1'b0;
        #1;
        chk("t6_async_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("t6_async_s_tready", 32'(s_tready), 32'd0);
        chk("t6_async_m_tid", 32'(m_tid), 32'd0);
        chk("t6_async_m_tdata", 32'(m_tdata), 32'd0);
        for (int p = 0; p < NP; p++) src_q[p].delete();
        src_q[1].push_back(8'h71);
        src_q[3].push_back(8'h81);
        sb.push_back({2'd1, 8'h71});
        sb.push_back({2'd3, 8'h81});
        m_tready = 1'b1;
        refresh();
        @(posedge aclk);
        cyc++;
        #1;
        chk("t6_inrst_m_tvalid", 32'(m_tvalid), 32'd0);
        aresetn = 1'b1;
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- N-to-1 AXI-Stream beat arbiter: shares one downstream AXIS sink among NUM_PORTS upstream AXIS sources.
- Round-robin grant with a bounded burst length per grant; single registered output stage.
- Sits between multiple AXIS masters (e.g. agent drivers or DMA channels) and one AXIS slave.
- m_tid reports the source port of each output beat.

Parameters:
- NUM_PORTS, 4, number of upstream ports (2..16).
- TDATA_BYTES, 1, tdata width in bytes, same on all ports.
- MAX_BURST, 4, maximum beats accepted per grant before forced rotation (1..255).

Ports:
- aclk  input  1  clock.
- aresetn  input  1  asynchronous active-low reset.
- s_tdata  input  NUM_PORTS*TDATA_BYTES*8  upstream data; port i occupies slice [i*TDATA_BYTES*8 +: TDATA_BYTES*8].
- s_tvalid  input  NUM_PORTS  upstream valid, one bit per port.
- s_tready  output  NUM_PORTS  upstream ready, one-hot or zero.
- m_tdata  output  TDATA_BYTES*8  downstream data, registered.
- m_tvalid  output  1  downstream valid, registered.
- m_tready  input  1  downstream ready.
- m_tid  output  $clog2(NUM_PORTS)  source port of the current m_tdata, registered.

Behaviour:
- Reset, async on aresetn low: state=IDLE, rr_ptr=0, grant=0, burst_cnt=0, m_tvalid=0, m_tdata=0, m_tid=0, s_tready=0. Any beat held in the output register is discarded. Outputs hold these values until the first aclk edge after release.
- FSM states:
  - IDLE: if any s_tvalid is set, choose the first set index scanning upward from rr_ptr with wrap-around modulo NUM_PORTS. Register it as grant, clear burst_cnt, go to GRANT. Else stay in IDLE. s_tready=0 in IDLE.
  - GRANT: s_tready[grant] = s_tvalid[grant] & (!m_tvalid | m_tready), combinational. All other s_tready bits are 0.
- Handshake in GRANT (s_tvalid[grant] & s_tready[grant]):
  - Next edge: m_tdata <= slice[grant], m_tid <= grant, m_tvalid <= 1, burst_cnt++.
- Output register:
  - m_tvalid clears on m_tready when there is no simultaneous load.
  - Load and drain in the same cycle gives back-to-back beats at one beat per clock.
  - m_tdata and m_tid are stable while m_tvalid & !m_tready.
- Release conditions, evaluated in GRANT; either sends the FSM to IDLE and sets rr_ptr <= (grant+1) mod NUM_PORTS:
  - (a) s_tvalid[grant]==0 in any GRANT cycle.
  - (b) a handshake occurs with burst_cnt==MAX_BURST-1.
- Latency:
  - Request in IDLE at cycle 0 → grant at edge 1 → first handshake in cycle 1 if the output is free → m_tvalid at edge 2.
  - Re-arbitration costs one bubble cycle (IDLE).
- Backpressure: m_tready low with m_tvalid high forces s_tready=0. The grant is held and burst_cnt is frozen. Stalled cycles do not count toward MAX_BURST.
- Fairness: every continuously requesting port is granted within NUM_PORTS-1 intervening grants.
- Simultaneous events:
  - Release and a new request on another port in the same cycle: the new request is arbitrated in the following IDLE cycle.
  - Port grant+1 requesting at release: it wins next.
  - A sole requester is regranted after each release, with one bubble.
- AXIS rule: the arbiter never depends on upstream dropping tvalid mid-beat. Release (a) occurs only when no beat is offered.

Test Plan:
- Single port 2 streams 10 beats 0x00..0x09, m_tready=1 → m_tdata 0x00..0x09 in order, m_tid=2 throughout; first m_tvalid 2 clocks after the request; one bubble after every 4 beats (MAX_BURST=4).
- All 4 ports continuously valid, port i data=0xi0+n, m_tready=1 → m_tid sequence 0,0,0,0,1,1,1,1,2,…,3,0; no beat lost or duplicated.
- Ports 1 and 3 valid, rr_ptr=2 at arbitration → port 3 granted first, then port 1 (wrap-around).
- Port 0 streaming, m_tready held low 5 cycles mid-burst → m_tdata and m_tid stable; s_tready[0]=0; burst_cnt unchanged; stream resumes with no lost beat.
- Port 1 drops tvalid after 2 of 4 allowed beats while port 2 is waiting → grant releases; port 2 granted next cycle via IDLE; rr_ptr=2.
- aresetn low while m_tvalid=1 and a grant is active → m_tvalid, s_tready and m_tid go to 0 immediately (asynchronous); after release arbitration restarts from port 0.
